// File: rtl/neuron_seq_ctrl.sv
// Sequencer for one Neuron image pass: issues ROWS row selects, fires each row's
// Reg_Stage capture LAT1 cycles later, waits LAT2 more cycles for the final
// result, pulses ENX for the output flop and then reports done.
module neuron_seq_ctrl #(
    parameter int unsigned ROWS = 28,
    parameter int unsigned LAT1 = 6,
    parameter int unsigned LAT2 = 5
) (
    input  logic            clk,
    input  logic            GlobalReset,
    input  logic            start,
    input  logic            abort,
    output logic            busy,
    output logic [4:0]      WeightX_Select,
    output logic [4:0]      PixelX_Select,
    output logic [ROWS-1:0] ENX_Int,
    output logic            ENX,
    output logic            done
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StIssue = 3'd1,
        StFlush = 3'd2,
        StFinal = 3'd3,
        StDone  = 3'd4
    } state_e;

    localparam logic [4:0] RowLast = 5'(ROWS - 1);
    // FLUSH spans the LAT1 capture tail after the last row plus LAT2 settle cycles.
    localparam logic [4:0] FlushLoad = 5'(LAT1 + LAT2 - 1);

    state_e                     state_q, state_d;
    logic [4:0]                 row_q, row_d;
    logic [4:0]                 flush_q, flush_d;
    logic [LAT1-1:0]            dl_valid_q;
    logic [LAT1-1:0][4:0]       dl_row_q;
    logic                       in_flight;
    logic                       kill;
    logic                       issue_valid;

    assign in_flight   = (state_q == StIssue) || (state_q == StFlush) || (state_q == StFinal);
    assign kill        = abort && in_flight;
    assign issue_valid = (state_q == StIssue);

    // Next-state logic for the FSM, row counter and FLUSH down-counter.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        flush_d = flush_q;
        unique case (state_q)
            StIdle: begin
                if (start && !abort) state_d = StIssue;
            end
            StIssue: begin
                if (row_q == RowLast) begin
                    state_d = StFlush;
                    row_d   = 5'd0;
                    flush_d = FlushLoad;
                end else begin
                    row_d = row_q + 5'd1;
                end
            end
            StFlush: begin
                if (flush_q == 5'd0) state_d = StFinal;
                else                 flush_d = flush_q - 5'd1;
            end
            StFinal: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (kill) begin
            state_d = StIdle;
            row_d   = 5'd0;
            flush_d = 5'd0;
        end
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!GlobalReset) begin
            state_q <= StIdle;
            row_q   <= 5'd0;
            flush_q <= 5'd0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            flush_q <= flush_d;
        end
    end

    // Token delay line: each issued row re-emerges LAT1 cycles later as a capture enable.
    always_ff @(posedge clk) begin
        if (!GlobalReset || kill) begin
            dl_valid_q <= '0;
            dl_row_q   <= '0;
        end else begin
            dl_valid_q[0] <= issue_valid;
            dl_row_q[0]   <= row_q;
            for (int i = 1; i < int'(LAT1); i++) begin
                dl_valid_q[i] <= dl_valid_q[i-1];
                dl_row_q[i]   <= dl_row_q[i-1];
            end
        end
    end

    // Moore outputs decoded from the state and the delay-line tail.
    always_comb begin
        busy           = in_flight;
        WeightX_Select = issue_valid ? row_q : 5'd0;
        PixelX_Select  = issue_valid ? row_q : 5'd0;
        ENX            = (state_q == StFinal);
        done           = (state_q == StDone);
        ENX_Int        = '0;
        for (int k = 0; k < int'(ROWS); k++) begin
            ENX_Int[k] = dl_valid_q[LAT1-1] && (dl_row_q[LAT1-1] == 5'(k));
        end
    end

endmodule

// File: tb/tb_neuron_seq_ctrl.sv
// Self-checking bench for neuron_seq_ctrl: directed timing scenarios, a vector
// table for reset/start/abort interplay, and random stimulus against a model
// that predicts every output from the cycle at which the current image started.
module tb_neuron_seq_ctrl;

    localparam int ROWS   = 28;
    localparam int LAT1   = 6;
    localparam int LAT2   = 5;
    localparam int DFINAL = ROWS + 1 + LAT1 + LAT2;
    localparam int DDONE  = DFINAL + 1;

    logic            clk = 1'b0;
    logic            rst_n, start, abort;
    logic            busy, enx, done;
    logic [4:0]      wsel, psel;
    logic [ROWS-1:0] enx_int;

    neuron_seq_ctrl #(.ROWS(ROWS), .LAT1(LAT1), .LAT2(LAT2)) dut (
        .clk            (clk),
        .GlobalReset    (rst_n),
        .start          (start),
        .abort          (abort),
        .busy           (busy),
        .WeightX_Select (wsel),
        .PixelX_Select  (psel),
        .ENX_Int        (enx_int),
        .ENX            (enx),
        .done           (done)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    // Model: an image is fully described by the cycle its start was accepted.
    bit have = 0;
    int t_acc = 0;

    int enx_at = -1, done_at = -1, int0_at = -1, int27_at = -1;
    int busy_cnt = 0;
    logic busy_prev = 1'b0;
    int rises[$];
    int dones[$];

    typedef struct {
        logic rst_n;
        logic start;
        logic abort;
        logic exp_busy;
        logic [4:0] exp_sel;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic compare_all();
        int d;
        int idx;
        logic            e_busy, e_enx, e_done;
        logic [4:0]      e_sel;
        logic [ROWS-1:0] e_int;
        d      = cyc - t_acc;
        idx    = d - 1 - LAT1;
        e_busy = have && d >= 1 && d <= DFINAL;
        e_sel  = (have && d >= 1 && d <= ROWS) ? 5'(d - 1) : 5'd0;
        e_int  = '0;
        if (have && idx >= 0 && idx < ROWS) e_int[idx] = 1'b1;
        e_enx  = have && d == DFINAL;
        e_done = have && d == DDONE;
        chk("busy", 32'(busy), 32'(e_busy));
        chk("wsel", 32'(wsel), 32'(e_sel));
        chk("psel", 32'(psel), 32'(e_sel));
        chk("enx_int", 32'(enx_int), 32'(e_int));
        chk("enx", 32'(enx), 32'(e_enx));
        chk("done", 32'(done), 32'(e_done));
        chk("enx_int_onehot0", 32'($countones(enx_int) <= 1), 32'd1);
        chk("enx_done_excl", 32'(enx && done), 32'd0);
    endtask

    // One clock: update the model with the inputs of the ending cycle, then check.
    task automatic step();
        int d;
        @(posedge clk);
        d = cyc - t_acc;
        if (!rst_n) have = 0;
        else if (have && d >= 1 && d <= DFINAL && abort) have = 0;
        else if ((!have || d > DDONE) && start && !abort) begin
            have  = 1;
            t_acc = cyc;
        end
        cyc++;
        #1;
        compare_all();
        if (enx) enx_at = cyc;
        if (done) begin done_at = cyc; dones.push_back(cyc); end
        if (enx_int[0]) int0_at = cyc;
        if (enx_int[27]) int27_at = cyc;
        if (busy) busy_cnt++;
        if (busy && !busy_prev) rises.push_back(cyc);
        busy_prev = busy;
    endtask

    task automatic run_until(input int c);
        while (cyc < c) step();
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 5'd0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 5'd0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'd0};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 5'd0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'd0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd0};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        step(); step(); step();
        rst_n = 1'b1;

        // Nominal image, start sampled at cycle 10.
        run_until(10);
        start = 1'b1; step(); start = 1'b0;
        run_until(60);
        chk("nom_busy_rise", 32'(rises[0]), 32'd11);
        chk("nom_busy_len", 32'(busy_cnt), 32'd40);
        chk("nom_int0", 32'(int0_at), 32'd17);
        chk("nom_int27", 32'(int27_at), 32'd44);
        chk("nom_enx", 32'(enx_at), 32'd50);
        chk("nom_done", 32'(done_at), 32'd51);

        // Back-to-back with start held high; a start during DONE must not be taken.
        run_until(200);
        rises.delete(); dones.delete();
        start = 1'b1;
        run_until(290);
        start = 1'b0;
        run_until(340);
        chk("b2b_rise1", 32'(rises[0]), 32'd201);
        chk("b2b_rise2", 32'(rises[1]), 32'd243);
        chk("b2b_done1", 32'(dones[0]), 32'd241);
        chk("b2b_done2", 32'(dones[1]), 32'd283);

        // Abort mid-ISSUE, then restart two cycles later.
        run_until(400);
        start = 1'b1; step(); start = 1'b0;
        run_until(420);
        abort = 1'b1; step(); abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_sel", 32'(wsel), 32'd0);
        step();
        start = 1'b1; step(); start = 1'b0;
        run_until(480);
        chk("abort_restart_enx", 32'(enx_at), 32'd462);
        chk("abort_restart_done", 32'(done_at), 32'd463);

        // Reset during FLUSH discards the image.
        run_until(500);
        start = 1'b1; step(); start = 1'b0;
        run_until(535);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        run_until(600);
        chk("rst_no_enx", 32'(enx_at), 32'd462);
        chk("rst_no_done", 32'(done_at), 32'd463);

        // Vector table: reset/start/abort priority from IDLE and ISSUE.
        for (int i = 0; i < 9; i++) begin
            rst_n = vecs[i].rst_n; start = vecs[i].start; abort = vecs[i].abort;
            step();
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            chk($sformatf("vec%0d_sel", i), 32'(wsel), 32'(vecs[i].exp_sel));
        end
        rst_n = 1'b1; start = 1'b0; abort = 1'b0;

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 3) == 0);
            abort = ($urandom_range(0, 39) == 0);
            rst_n = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n = 1'b1; start = 1'b0; abort = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
